// File: rtl/seg7_pkg.sv
// Shared widths, segment codes and helpers for the seg7_scan_mux display driver.
// Segment codes are stored active-low, ordered a..g (index 0 = a).
package seg7_pkg;

    localparam int SEG_W = 7;
    localparam int BCD_W = 4;

    typedef logic [0:SEG_W-1] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    // 10..15 hold the hex glyphs; the decoder decides whether to use them.
    localparam seg_t SEG_LUT [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_scan_mux_if.sv
// Data/display bundle for seg7_scan_mux: the master loads BCD words, the slave drives the pins.
interface seg7_scan_mux_if #(
    parameter int NUM_DIGITS = 4
);
    import seg7_pkg::*;

    localparam int IDX_W = idx_width(NUM_DIGITS);

    logic                        load;
    logic [BCD_W*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]       dp_in;
    logic                        lzb_en;
    seg_t                        seg_out;
    logic                        dp_out;
    logic [NUM_DIGITS-1:0]       an_out;
    logic [IDX_W-1:0]            digit_idx;

    modport master (
        output load, digits_in, dp_in, lzb_en,
        input  seg_out, dp_out, an_out, digit_idx
    );

    modport slave (
        input  load, digits_in, dp_in, lzb_en,
        output seg_out, dp_out, an_out, digit_idx
    );

endinterface

// File: rtl/seg7_decode_ext.sv
// Combinational 4-bit code to active-low segment decoder.
// Define SEG7_SCAN_HEX_DIGITS_EN to show A..F for codes 10..15; otherwise they blank.
module seg7_decode_ext
    import seg7_pkg::*;
(
    input  logic [BCD_W-1:0] code_i,
    output seg_t             seg_o
);

    always_comb begin
        seg_o = SEG_LUT[code_i];
`ifdef SEG7_SCAN_HEX_DIGITS_EN
`else
        if (code_i > BCD_W'(9)) begin
            seg_o = SEG_BLANK;
        end
`endif
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed N-digit 7-segment driver with leading-zero blanking and decimal points.
// Optional hex glyphs for codes 10..15 via SEG7_SCAN_HEX_DIGITS_EN (see seg7_decode_ext).
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    seg7_scan_mux_if.slave  bus
);

    localparam int IDX_W = idx_width(NUM_DIGITS);
    localparam int PRE_W = $clog2(REFRESH_DIV);

    function automatic seg_t phys_seg(input seg_t s_lo);
        return SEG_ACTIVE_LOW ? s_lo : ~s_lo;
    endfunction

    function automatic logic phys_bit(input logic b_lo);
        return SEG_ACTIVE_LOW ? b_lo : ~b_lo;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] phys_an(input logic [NUM_DIGITS-1:0] a_lo);
        return SEG_ACTIVE_LOW ? a_lo : ~a_lo;
    endfunction

    logic [PRE_W-1:0]            pre_q, pre_d;
    logic                        tick;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [BCD_W*NUM_DIGITS-1:0] dig_q, dig_d;
    logic [NUM_DIGITS-1:0]       dpsh_q, dpsh_d;
    seg_t                        seg_q, seg_d;
    logic                        dpo_q, dpo_d;
    logic [NUM_DIGITS-1:0]       an_q, an_d;

    logic [NUM_DIGITS-1:0]       blank_vec;
    logic                        zero_above;
    logic [BCD_W-1:0]            sel_code;
    logic                        sel_dp;
    logic                        sel_blank;
    seg_t                        dec_seg;

    always_comb begin
        tick  = (pre_q == PRE_W'(REFRESH_DIV - 1));
        pre_d = tick ? '0 : pre_q + PRE_W'(1);
        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        dig_d  = dig_q;
        dpsh_d = dpsh_q;
        if (bus.load) begin
            dig_d  = bus.digits_in;
            dpsh_d = bus.dp_in;
        end
    end

    // Walk from the most significant digit down; a digit blanks while everything above it is zero.
    always_comb begin
        blank_vec  = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above   = zero_above & (dig_q[i*BCD_W +: BCD_W] == '0);
            blank_vec[i] = bus.lzb_en & zero_above;
        end
    end

    // Outputs are prepared for the index being entered, so they land together with the tick.
    always_comb begin
        sel_code  = '0;
        sel_dp    = 1'b0;
        sel_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                sel_code  = dig_q[i*BCD_W +: BCD_W];
                sel_dp    = dpsh_q[i];
                sel_blank = blank_vec[i];
            end
        end
    end

    seg7_decode_ext u_decode (
        .code_i (sel_code),
        .seg_o  (dec_seg)
    );

    always_comb begin
        seg_d = seg_q;
        dpo_d = dpo_q;
        an_d  = an_q;
        if (tick) begin
            seg_d = phys_seg(sel_blank ? SEG_BLANK : dec_seg);
            dpo_d = phys_bit(~sel_dp);
            an_d  = phys_an(~(NUM_DIGITS'(1) << idx_d));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q  <= '0;
            idx_q  <= IDX_W'(NUM_DIGITS - 1);
            dig_q  <= '0;
            dpsh_q <= '0;
            seg_q  <= phys_seg(SEG_BLANK);
            dpo_q  <= phys_bit(1'b1);
            an_q   <= phys_an('1);
        end else begin
            pre_q  <= pre_d;
            idx_q  <= idx_d;
            dig_q  <= dig_d;
            dpsh_q <= dpsh_d;
            seg_q  <= seg_d;
            dpo_q  <= dpo_d;
            an_q   <= an_d;
        end
    end

    assign bus.seg_out   = seg_q;
    assign bus.dp_out    = dpo_q;
    assign bus.an_out    = an_q;
    assign bus.digit_idx = idx_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Randomised bench for seg7_scan_mux (4 digits, 4-cycle slots, active-low) against a slot-level model.
module tb_seg7_scan_mux;

    localparam int ND = 4;
    localparam int RD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seg7_scan_mux_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_mux #(
        .NUM_DIGITS     (ND),
        .REFRESH_DIV    (RD),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [0:6] seg_of(input int v);
        case (v)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
`ifdef SEG7_SCAN_HEX_DIGITS_EN
            10: return 7'b0001000;
            11: return 7'b1100000;
            12: return 7'b0110001;
            13: return 7'b1000010;
            14: return 7'b0110000;
            15: return 7'b0111000;
`endif
            default: return 7'b1111111;
        endcase
    endfunction

    // Model: cycles since reset decide the slot; slot k (k>=1) shows digit (k-1) mod ND.
    int          m_cnt;
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic [0:6]  exp_seg;
    logic        exp_dp;
    logic [3:0]  exp_an;
    int          exp_idx;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt   = 0;
            m_val   = 16'h0;
            m_dp    = 4'h0;
            exp_seg = 7'b1111111;
            exp_dp  = 1'b1;
            exp_an  = 4'hf;
            exp_idx = ND - 1;
        end else begin
            m_cnt++;
            if (m_cnt % RD == 0) begin
                int d;
                int v;
                bit blank;
                d       = ((m_cnt / RD) - 1) % ND;
                v       = (m_val >> (4 * d)) & 15;
                blank   = bus.lzb_en && d > 0 && ((m_val >> (4 * d)) == 0);
                exp_seg = blank ? 7'b1111111 : seg_of(v);
                exp_dp  = ~m_dp[d];
                exp_an  = ~(4'b0001 << d);
                exp_idx = d;
            end
            if (bus.load) begin
                m_val = bus.digits_in;
                m_dp  = bus.dp_in;
            end
        end
    end

    always @(negedge clk) begin
        check("seg_out", 32'(bus.seg_out), 32'(exp_seg));
        check("dp_out", 32'(bus.dp_out), 32'(exp_dp));
        check("an_out", 32'(bus.an_out), 32'(exp_an));
        check("digit_idx", 32'(bus.digit_idx), 32'(exp_idx));
    end

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
        bus.digits_in = v;
        bus.dp_in     = dp;
        bus.load      = 1'b1;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
    endtask

    task automatic settle();
        repeat (RD) @(posedge clk);
        #1;
    endtask

    // Returns #1 after the edge where an_out switches to tgt.
    task automatic wait_an(input logic [3:0] tgt);
        logic [3:0] prev;
        bit found;
        prev  = bus.an_out;
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(posedge clk);
            #1;
            if (bus.an_out == tgt && prev != tgt) found = 1;
            prev = bus.an_out;
        end
        if (!found) begin
            tests++;
            fails++;
            $display("FAIL wait_an: timeout, an_out %b never became %b", bus.an_out, tgt);
        end
    endtask

    initial begin
        bus.load      = 1'b0;
        bus.digits_in = '0;
        bus.dp_in     = '0;
        bus.lzb_en    = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("an_before_first_tick", 32'(bus.an_out), 32'h0000000f);
        end
        @(posedge clk);
        #1;
        check("first_an", 32'(bus.an_out), 32'h0000000e);
        check("first_seg_zero", 32'(bus.seg_out), 32'(7'b0000001));

        // 1234, no blanking
        do_load(16'h1234, 4'h0);
        settle();
        wait_an(4'b1110);
        check("d0_of_1234", 32'(bus.seg_out), 32'(7'b1001100));
        wait_an(4'b0111);
        check("d3_of_1234", 32'(bus.seg_out), 32'(7'b1001111));
        repeat (16) @(posedge clk);

        // 0007 with and without blanking
        bus.lzb_en = 1'b1;
        do_load(16'h0007, 4'h0);
        settle();
        wait_an(4'b0111);
        check("lzb_d3_blank", 32'(bus.seg_out), 32'(7'b1111111));
        wait_an(4'b1110);
        check("lzb_d0_seven", 32'(bus.seg_out), 32'(7'b0001111));
        bus.lzb_en = 1'b0;
        wait_an(4'b0111);
        check("nolzb_d3_zero", 32'(bus.seg_out), 32'(7'b0000001));

        // 00A5: hex build vs. decimal build
        do_load(16'h00A5, 4'h0);
        settle();
        wait_an(4'b1101);
`ifdef SEG7_SCAN_HEX_DIGITS_EN
        check("d1_code_A", 32'(bus.seg_out), 32'(7'b0001000));
`else
        check("d1_code_A", 32'(bus.seg_out), 32'(7'b1111111));
`endif
        wait_an(4'b1110);
        check("d0_of_A5", 32'(bus.seg_out), 32'(7'b0100100));

        // Load in the middle of digit 2's slot
        wait_an(4'b1011);
        check("d2_before_load", 32'(bus.seg_out), 32'(7'b0000001));
        do_load(16'h0800, 4'h0);
        check("d2_holds_midslot", 32'(bus.seg_out), 32'(7'b0000001));
        wait_an(4'b1011);
        check("d2_after_load", 32'(bus.seg_out), 32'(7'b0000000));

        // Decimal point on a blanked digit
        bus.lzb_en = 1'b1;
        do_load(16'h0000, 4'b0100);
        settle();
        wait_an(4'b1011);
        check("dp_d2_on", 32'(bus.dp_out), 32'(1'b0));
        check("dp_d2_blank", 32'(bus.seg_out), 32'(7'b1111111));
        wait_an(4'b0111);
        check("dp_d3_off", 32'(bus.dp_out), 32'(1'b1));

        // Asynchronous reset between edges
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_seg", 32'(bus.seg_out), 32'(7'b1111111));
        check("rst_an", 32'(bus.an_out), 32'h0000000f);
        check("rst_dp", 32'(bus.dp_out), 32'(1'b1));
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            bus.lzb_en = 1'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                logic [15:0] r;
                r = 16'($urandom);
                case ($urandom_range(0, 3))
                    0: r = r & 16'h000f;
                    1: r = r & 16'h00ff;
                    2: r = r & 16'h0f0f;
                    default: ;
                endcase
                bus.digits_in = r;
                bus.dp_in     = 4'($urandom);
                bus.load      = 1'b1;
            end else begin
                bus.load = 1'b0;
            end
            if (c == 200) begin
                #3 rst = 1'b1;
                @(posedge clk);
                #2 rst = 1'b0;
            end
        end
        bus.load = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
- Time-multiplexed N-digit 7-segment display driver.
- Latches a packed BCD word and scans one digit at a time through shared segment lines plus per-digit anode enables.
- Supports leading-zero blanking and per-digit decimal points.
- Sits between the BCD up/down counters and the board display pins; replaces per-digit static decoders.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8).
- REFRESH_DIV, 50000, clk cycles per digit slot (>=2).
- SEG_ACTIVE_LOW, 1, 1 = segment/anode/dp outputs active-low; 0 = active-high.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- load  input  1  one-cycle strobe; captures digits_in and dp_in.
- digits_in  input  4*NUM_DIGITS  packed BCD; digit 0 = bits [3:0] = least significant.
- dp_in  input  NUM_DIGITS  decimal point request per digit.
- lzb_en  input  1  leading-zero blanking enable (sampled live).
- seg_out  output  [0:6]  segments a..g; index 0 = a, index 6 = g.
- dp_out  output  1  decimal point of the selected digit.
- an_out  output  NUM_DIGITS  digit enables; one-hot when a digit is active.
- digit_idx  output  $clog2(NUM_DIGITS) (min 1)  index of the currently driven digit.

Behaviour:
- Interface: single clock domain, clk. rst is asynchronous and active-high; it takes effect immediately regardless of clk.
- Reset values:
  - prescaler = 0.
  - digit_idx = NUM_DIGITS-1.
  - shadow registers = 0.
  - seg_out, dp_out, an_out all inactive (all 1s when SEG_ACTIVE_LOW=1).
- Shadow capture: when load=1 at a clk edge, shadow <= {digits_in, dp_in}. The new values are used from the next digit slot onward; the current slot's registered outputs do not change mid-slot.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. tick = (prescaler == REFRESH_DIV-1).
- Scan sequence:
  - On tick: digit_idx <= (digit_idx == NUM_DIGITS-1) ? 0 : digit_idx+1.
  - At the same edge, seg_out, dp_out and an_out are registered for the new index; there is 1 cycle of latency from tick.
  - The first tick after reset therefore shows digit 0 at cycle REFRESH_DIV.
- Segment map (active-low form, a..g): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100. Codes 10..15 = all off (unless HEX_DIGITS_EN).
- SEG_ACTIVE_LOW=0 inverts seg_out, dp_out and an_out.
- Leading-zero blanking: when lzb_en=1, digit i>0 is blanked if digit i and every more-significant digit are 0.
  - Blanked = segments off; the anode is still driven.
  - dp_in for a blanked digit is still honoured.
  - Digit 0 is never blanked.
- NUM_DIGITS=1: digit_idx stays 0; outputs refresh on every tick.
- Reset mid-scan: all outputs go inactive immediately; the scan restarts from the reset values.

Optional Feature:
- Macro: SEG7_SCAN_HEX_DIGITS_EN.
- Defined: codes 10..15 decode to A, b, C, d, E, F (active-low A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000). Leading-zero blanking still treats only value 0 as zero.
- Undefined: codes 10..15 drive all segments off.

Decomposition:
- Package seg7_pkg holds:
  - SEG_W=7 and BCD_W=4.
  - A segment-code constant array for 0..15.
  - The SEG_BLANK constant.
- Sub-module seg7_decode_ext: purely combinational code to segments, honouring SEG7_SCAN_HEX_DIGITS_EN. It is instantiated once on the muxed digit.
- The top level holds the prescaler, scan counter, shadow registers, blanking logic and output registers.

Test Plan (bench uses NUM_DIGITS=4, REFRESH_DIV=4, SEG_ACTIVE_LOW=1):
- Reset asserted mid-cycle -> seg_out=1111111, an_out=1111, dp_out=1 immediately; first an_out=1110 appears at cycle 4 after release.
- load digits_in=16'h1234, lzb_en=0 -> slots cycle an_out 1110/1101/1011/0111 with seg_out 4 (1001100), 3, 2, 1; the pattern repeats every 16 cycles.
- load 16'h0007, lzb_en=1 -> digits 3..1 show 1111111 with anodes still cycling; digit 0 shows 0001111. With lzb_en=0, digits 3..1 show 0000001.
- load 16'h00A5 -> with the macro undefined, digit 1 = 1111111; with it defined, digit 1 = 0001000. Digit 0 shows 0100100 in both builds.
- load during an active slot of digit 2 -> digit 2 holds its old code until the next tick; the new value appears from the next slot.
- dp_in=4'b0100, lzb_en=1, value 16'h0000 -> dp_out=0 only while an_out=1011, with that digit's segments blanked.
